// File: rtl/ff256_ct_seq_pkg.sv
// Shared constants, state encoding and selector types for the GF(256)
// cosine-transform sequencer.
package ff256_ct_seq_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [SEL_W-1:0] sel_arr_t [0:N_LANES-1];

  // Lane k reads byte (k + step) mod N_LANES; the 3-bit add drops its carry.
  function automatic logic [SEL_W-1:0] lane_sel(input logic [SEL_W-1:0] lane,
                                                 input logic [SEL_W-1:0] step);
    return lane + step;
  endfunction

endpackage

// File: rtl/ff256_ct_seq_step_counter.sv
// 3-bit step counter with synchronous clear/enable and a wrap flag that
// marks the last step of a transform.
module ff256_ct_seq_step_counter
  import ff256_ct_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] step,
  output logic             wrap
);

  logic [SEL_W-1:0] step_q;
  logic [SEL_W-1:0] step_d;

  always_comb begin
    step_d = step_q;
    if (clr) begin
      step_d = '0;
    end else if (en) begin
      step_d = step_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step = step_q;
  assign wrap = en & (&step_q);

endmodule

// File: rtl/ff256_ct_seq_controller.sv
// Sequencer for the 8-lane GF(256) cosine-transform datapath: latches a
// 64-bit vector, rotates lane selectors for 8 cycles, then presents the
// result. Define FF256_CT_SEQ_CTRL_BACKPRESSURE_EN to make DONE wait for
// out_ready; otherwise DONE is a single-cycle out_valid pulse.
module ff256_ct_seq_controller
  import ff256_ct_seq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_LANES*8-1:0]       x_in,
  output logic [N_LANES*8-1:0]       x_hold,
  output logic [SEL_W-1:0]           selector [0:N_LANES-1],
  output logic                       acc_clear,
  output logic                       acc_en,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready
);

  state_e                 state_q;
  state_e                 state_d;
  logic [N_LANES*8-1:0]   x_hold_q;
  logic [N_LANES*8-1:0]   x_hold_d;
  logic [SEL_W-1:0]       step;
  logic                   step_wrap;
  logic                   accept;
  logic                   step_clr;
  logic                   step_en;

  // flush outranks everything, including an input offered in IDLE.
  assign accept   = (state_q == IDLE) & in_valid & ~flush;
  assign step_clr = flush | accept;
  assign step_en  = (state_q == RUN) & ~flush;

  ff256_ct_seq_step_counter u_step (
    .clk  (clk),
    .rst  (rst),
    .clr  (step_clr),
    .en   (step_en),
    .step (step),
    .wrap (step_wrap)
  );

`ifdef FF256_CT_SEQ_CTRL_BACKPRESSURE_EN
  logic done_release;
  assign done_release = out_ready;
`else
  logic done_release;
  logic unused_out_ready;
  assign done_release     = 1'b1;
  assign unused_out_ready = out_ready;
`endif

  always_comb begin
    state_d  = state_q;
    x_hold_d = x_hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          x_hold_d = x_in;
        end
      end
      RUN: begin
        if (step_wrap) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_release) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      x_hold_q <= x_hold_d;
    end
  end

  // Every output is decoded from registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign acc_en    = (state_q == RUN);
  assign acc_clear = (state_q == RUN) & (step == '0);
  assign x_hold    = x_hold_q;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign selector[k] = lane_sel(SEL_W'(k), step);
  end

endmodule

// File: tb/tb_ff256_ct_seq_controller.sv
// Scoreboarded bench for ff256_ct_seq_controller: directed transforms,
// backpressure/pulse DONE, flush, async reset mid-RUN and back-to-back.
module tb_ff256_ct_seq_controller;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] x_in;
  logic [63:0] x_hold;
  logic [2:0]  sel [0:7];
  logic        acc_clear;
  logic        acc_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  ff256_ct_seq_controller dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .x_hold    (x_hold),
    .selector  (sel),
    .acc_clear (acc_clear),
    .acc_en    (acc_en),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed handshake must match the oldest accepted vector.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
`ifdef FF256_CT_SEQ_CTRL_BACKPRESSURE_EN
      if (out_ready) begin
`else
      begin
`endif
        if (exp_q.size() == 0) chk("sb_unexpected_out_valid", 64'd1, 64'd0);
        else                   chk("sb_x_hold", x_hold, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1 with the DUT in IDLE and out_ready low.
  task automatic run_nominal(input logic [63:0] x);
    x_in     = x;
    in_valid = 1'b1;
    @(negedge clk);
    chk("accept_in_ready", in_ready, 1);
    exp_q.push_back(x);
    step_clk();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("run_acc_en", acc_en, 1);
      chk("run_acc_clear", acc_clear, (i == 0));
      chk("run_sel0", sel[0], i[2:0]);
      chk("run_sel3", sel[3], (i + 3) % 8);
      chk("run_in_ready", in_ready, 0);
      chk("run_out_valid", out_valid, 0);
      chk("run_x_hold", x_hold, x);
      step_clk();
    end
    @(negedge clk);
    chk("done_out_valid", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    chk("done_acc_en", acc_en, 0);
    chk("done_sel_identity", sel[3], 3);
`ifdef FF256_CT_SEQ_CTRL_BACKPRESSURE_EN
    for (int j = 0; j < 4; j++) begin
      step_clk();
      @(negedge clk);
      chk("bp_out_valid_hold", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
    end
    step_clk();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 1);
    step_clk();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_in_ready", in_ready, 1);
    chk("bp_after_out_valid", out_valid, 0);
`else
    step_clk();
    @(negedge clk);
    chk("pulse_out_valid_low", out_valid, 0);
    chk("pulse_idle_in_ready", in_ready, 1);
`endif
    step_clk();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    x_in      = 64'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_x_hold", x_hold, 0);
    for (int k = 0; k < 8; k++) chk("rst_sel_identity", sel[k], k[2:0]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step_clk();

    run_nominal(64'h0706050403020100);
    run_nominal(64'hDEAD_BEEF_0123_4567);

    // flush at RUN step 4
    x_in     = 64'hA5A5_5A5A_F00D_CAFE;
    in_valid = 1'b1;
    step_clk();
    in_valid = 1'b0;
    repeat (4) step_clk();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_sel0", sel[0], 4);
    chk("flush_pre_acc_en", acc_en, 1);
    step_clk();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_acc_en", acc_en, 0);
    chk("flush_acc_clear", acc_clear, 0);
    chk("flush_sel3", sel[3], 3);
    chk("flush_sel7", sel[7], 7);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_x_hold_kept", x_hold, 64'hA5A5_5A5A_F00D_CAFE);
    repeat (12) step_clk();

    // flush in IDLE rejects an offered input
    x_in     = 64'h1111_2222_3333_4444;
    in_valid = 1'b1;
    flush    = 1'b1;
    step_clk();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    chk("flush_idle_in_ready", in_ready, 1);
    chk("flush_idle_acc_en", acc_en, 0);
    chk("flush_idle_x_hold", x_hold, 64'hA5A5_5A5A_F00D_CAFE);
    step_clk();
    run_nominal(64'h0F1E_2D3C_4B5A_6978);

    // asynchronous reset at RUN step 5
    x_in     = 64'h8877_6655_4433_2211;
    in_valid = 1'b1;
    step_clk();
    in_valid = 1'b0;
    repeat (5) step_clk();
    @(negedge clk);
    chk("arst_pre_sel0", sel[0], 5);
    chk("arst_pre_x_hold", x_hold, 64'h8877_6655_4433_2211);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_acc_en", acc_en, 0);
    chk("arst_acc_clear", acc_clear, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_x_hold", x_hold, 0);
    chk("arst_sel0", sel[0], 0);
    chk("arst_sel5", sel[5], 5);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) step_clk();

    // back-to-back with in_valid held high and out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      x_in = {$urandom(), $urandom()};
      @(negedge clk);
      chk("b2b_in_ready", in_ready, (cyc % 10) == 0);
      chk("b2b_out_valid", out_valid, (cyc % 10) == 9);
      if ((cyc % 10) == 0) exp_q.push_back(x_in);
      step_clk();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (12) step_clk();

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff256_ct_seq_controller.md
# ff256_ct_seq_controller

Sequencer for the sequential GF(256) cosine-transform datapath. It accepts one 64-bit input vector (eight bytes) per transform and holds it stable for the 8-lane multiplier input multiplexer. Over eight cycles it drives the eight 3-bit lane selectors on a rotating schedule and generates the accumulator clear and enable strobes. It then presents the result with a valid/ready handshake.

## Interface
Parameters:
- N_LANES, 8, number of multiplier lanes and input bytes; fixed at 8
- SEL_W, 3, selector width, log2(N_LANES)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input vector offered
- in_ready  output  1  controller can accept a vector
- x_in  input  64  input vector; byte n = x_in[8n+7:8n]
- x_hold  output  64  registered copy of the accepted vector, driven to the multiplexer
- selector  output  SEL_W x [0:N_LANES-1]  per-lane byte select to the multiplexer
- acc_clear  output  1  accumulators load the product instead of adding it
- acc_en  output  1  accumulators update this cycle
- flush  input  1  synchronous abort
- out_valid  output  1  accumulator result valid
- out_ready  input  1  downstream accepts the result

## Operation
- FSM states: IDLE, RUN, DONE. Step counter `step` is 3 bits.
- IDLE:
  - in_ready=1.
  - On in_valid: load x_hold<=x_in, clear step to 0, go to RUN.
- RUN:
  - acc_en=1; acc_clear=1 only when step==0.
  - selector[k] = (k + step) mod 8, using 3-bit wrap-around addition with no carry out.
  - step increments each cycle.
  - After the cycle with step==7, step wraps to 0 and the FSM goes to DONE.
- DONE:
  - out_valid=1; acc_en=0.
  - On out_ready, go to IDLE.
- Outside RUN: step==0, so selector[k]=k (identity mapping).
- x_hold changes only on an accepted input.
- in_ready is 0 in RUN and DONE. There is no overlap between transforms.
- flush:
  - Forces IDLE and step=0 on the next edge from any state.
  - Clears out_valid. x_hold is retained.
  - Has priority over in_valid, step advance and out_ready in the same cycle.
  - A flush in IDLE with in_valid high rejects the input (no load). in_ready stays combinationally high; the bench must treat flush as gating the accept.
- Reset values (asynchronous, immediate):
  - state=IDLE, step=0, x_hold=0.
  - out_valid=0, acc_en=0, acc_clear=0, in_ready=1, selector[k]=k.
- Reset mid-RUN discards the transform. No partial out_valid is produced.

## Timing
- Accept at edge T (in_valid & in_ready sampled high).
- RUN occupies cycles T+1..T+8, with acc_clear high in cycle T+1.
- out_valid rises in cycle T+9.
- Minimum period per transform is 10 cycles: accept, 8 RUN, 1 DONE with out_ready=1.
- out_valid stays high until out_ready is sampled high. in_ready rises the following cycle.
- All outputs are registered or decoded from registered state; no input-to-output combinational path. Exception: none of in_ready, out_valid or selector depends on current-cycle inputs.

## Configuration
- FF256_CT_SEQ_CTRL_BACKPRESSURE_EN defined:
  - DONE waits for out_ready as described above.
- FF256_CT_SEQ_CTRL_BACKPRESSURE_EN undefined:
  - out_ready is ignored.
  - DONE lasts exactly one cycle (single-cycle out_valid pulse), then the FSM returns to IDLE.
  - Fixed 10-cycle throughput.

## Structure
- Shared package ff256_ct_seq_pkg holds:
  - N_LANES and SEL_W constants.
  - State enum typedef (IDLE, RUN, DONE).
  - Selector-array typedef.
- Sub-module ff256_ct_seq_step_counter:
  - 3-bit counter with clear/enable and a wrap flag (step==7 & en).
  - Reused by the controller for RUN termination.
- Selector rotation is generated in the controller with a generate loop over lanes.

## Test plan
- Reset, then x_in=64'h0706050403020100 with in_valid=1 for one cycle:
  - x_hold matches x_in.
  - acc_clear=1 only in cycle T+1.
  - selector[0] steps 0..7 and selector[3] steps 3,4,5,6,7,0,1,2.
  - out_valid rises at T+9.
- out_ready held low for 5 cycles in DONE (BACKPRESSURE_EN):
  - out_valid stays high and in_ready=0 throughout.
  - Release gives in_ready=1 on the next cycle.
- Same stimulus with the macro undefined and out_ready=0:
  - out_valid is high for exactly one cycle at T+9.
  - IDLE at T+10.
- flush asserted at RUN step 4:
  - IDLE next cycle, step=0, selectors identity, no out_valid.
  - The next transform behaves normally.
- rst asserted asynchronously mid-RUN (step 5):
  - Outputs go to reset values immediately.
  - x_hold=0; no out_valid.
- Back-to-back transforms with in_valid held high and out_ready=1:
  - Accepts occur 10 cycles apart.
  - in_valid offered during RUN is not accepted.
